// File: rtl/sonar_echo_capture.sv
// Sonar trigger/echo timer: fires a trigger pulse, then measures echo high time in microsecond ticks.
// Optional build macro SONAR_ECHO_FILTER_EN adds a 3-sample glitch filter after the synchroniser.
module sonar_echo_capture #(
  parameter int TICK_DIV   = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int WIDTH_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               echo,
  output logic               trig,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic               timeout,
  output logic [WIDTH_W-1:0] width_us
);

  localparam int PRESC_W = $clog2(TICK_DIV + 1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [WIDTH_W-1:0] CNT_ZERO   = {WIDTH_W{1'b0}};
  localparam logic [WIDTH_W-1:0] CNT_ONE    = {{(WIDTH_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_W-1:0] TRIG_LAST  = WIDTH_W'(TRIG_US - 1);
  localparam logic [WIDTH_W-1:0] WAIT_LAST  = WIDTH_W'(TIMEOUT_US - 1);
  localparam logic [WIDTH_W-1:0] LIMIT      = WIDTH_W'(TIMEOUT_US);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t               state_r;
  logic [PRESC_W-1:0]   presc_r;
  logic [WIDTH_W-1:0]   cnt_r;
  logic                 armed_r;
  logic                 trig_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 valid_r;
  logic                 timeout_r;
  logic [WIDTH_W-1:0]   width_r;

  logic                 echo_meta_r;
  logic                 echo_sync_r;
  logic                 echo_q_r;
  logic                 echo_edge_s;

  logic                 tick_s;
  logic [PRESC_W-1:0]   presc_next_s;
  logic [WIDTH_W-1:0]   cnt_inc_s;
  logic                 rise_s;
  logic                 fall_s;

  // Two-flop synchroniser for the asynchronous echo pin
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_meta_r <= 1'b0;
      echo_sync_r <= 1'b0;
    end else begin
      echo_meta_r <= echo;
      echo_sync_r <= echo_meta_r;
    end
  end

`ifdef SONAR_ECHO_FILTER_EN
  logic echo_d1_r;
  logic echo_d2_r;
  logic echo_hold_r;

  // Sample history and held filter value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_d1_r   <= 1'b0;
      echo_d2_r   <= 1'b0;
      echo_hold_r <= 1'b0;
    end else begin
      echo_d1_r   <= echo_sync_r;
      echo_d2_r   <= echo_d1_r;
      echo_hold_r <= echo_edge_s;
    end
  end

  // Follow the synchronised echo only once three consecutive samples agree
  always_comb begin
    if ((echo_sync_r == echo_d1_r) && (echo_d1_r == echo_d2_r)) begin
      echo_edge_s = echo_sync_r;
    end else begin
      echo_edge_s = echo_hold_r;
    end
  end
`else
  // Unfiltered build: edges come straight from the synchroniser
  always_comb begin
    echo_edge_s = echo_sync_r;
  end
`endif

  // Delayed copy of the edge source for rise/fall detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_q_r <= 1'b0;
    end else begin
      echo_q_r <= echo_edge_s;
    end
  end

  // Prescaler tick, counter increment and edge strobes
  always_comb begin
    tick_s       = (presc_r == PRESC_LAST);
    presc_next_s = tick_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
    cnt_inc_s    = tick_s ? (cnt_r + CNT_ONE) : cnt_r;
    rise_s       = echo_edge_s & ~echo_q_r;
    fall_s       = ~echo_edge_s & echo_q_r;
  end

  // Measurement sequencer with registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      presc_r   <= PRESC_ZERO;
      cnt_r     <= CNT_ZERO;
      armed_r   <= 1'b0;
      trig_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      width_r   <= CNT_ZERO;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          presc_r <= PRESC_ZERO;
          cnt_r   <= CNT_ZERO;
          if (start) begin
            state_r   <= ST_TRIG;
            trig_r    <= 1'b1;
            busy_r    <= 1'b1;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            width_r   <= CNT_ZERO;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_TRIG: begin
          if (tick_s && (cnt_r == TRIG_LAST)) begin
            state_r <= ST_WAIT_RISE;
            trig_r  <= 1'b0;
            presc_r <= PRESC_ZERO;
            cnt_r   <= CNT_ZERO;
            armed_r <= 1'b0;
          end else begin
            presc_r <= presc_next_s;
            cnt_r   <= cnt_inc_s;
          end
        end
        ST_WAIT_RISE: begin
          // A rise only counts once the echo has been seen low inside this state
          if (rise_s && armed_r) begin
            state_r <= ST_MEASURE;
            presc_r <= PRESC_ZERO;
            cnt_r   <= CNT_ZERO;
          end else if (tick_s && (cnt_r == WAIT_LAST)) begin
            state_r   <= ST_DONE;
            presc_r   <= PRESC_ZERO;
            cnt_r     <= CNT_ZERO;
            done_r    <= 1'b1;
            valid_r   <= 1'b1;
            timeout_r <= 1'b1;
            width_r   <= CNT_ZERO;
          end else begin
            presc_r <= presc_next_s;
            cnt_r   <= cnt_inc_s;
            armed_r <= armed_r | ~echo_edge_s;
          end
        end
        ST_MEASURE: begin
          // A fall on the limit tick still reports a normal end
          if (fall_s) begin
            state_r   <= ST_DONE;
            presc_r   <= PRESC_ZERO;
            cnt_r     <= CNT_ZERO;
            done_r    <= 1'b1;
            valid_r   <= 1'b1;
            timeout_r <= 1'b0;
            width_r   <= cnt_inc_s;
          end else if (cnt_inc_s == LIMIT) begin
            state_r   <= ST_DONE;
            presc_r   <= PRESC_ZERO;
            cnt_r     <= CNT_ZERO;
            done_r    <= 1'b1;
            valid_r   <= 1'b1;
            timeout_r <= 1'b1;
            width_r   <= LIMIT;
          end else begin
            presc_r <= presc_next_s;
            cnt_r   <= cnt_inc_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          presc_r <= PRESC_ZERO;
          cnt_r   <= CNT_ZERO;
        end
        default: begin
          state_r <= ST_IDLE;
          trig_r  <= 1'b0;
          busy_r  <= 1'b0;
          presc_r <= PRESC_ZERO;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign trig     = trig_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign valid    = valid_r;
  assign timeout  = timeout_r;
  assign width_us = width_r;

endmodule
